// File: rtl/div32by32.sv
// 32-by-32 unsigned restoring divider, one quotient bit per clock, MSB first.
// Divide-by-zero completes in one cycle and saturates the quotient.
module div32by32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    ZERO   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_dividend;
  logic [31:0] w_dividend_nxt;
  logic [31:0] r_divisor;
  logic [31:0] w_divisor_nxt;
  logic [31:0] r_rem;
  logic [31:0] w_rem_nxt;
  logic [31:0] r_quo;
  logic [31:0] w_quo_nxt;
  logic [4:0]  r_count;
  logic [4:0]  w_count_nxt;
  logic        r_busy;
  logic        w_busy_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic [31:0] r_quotient;
  logic [31:0] w_quotient_nxt;
  logic [31:0] r_remainder;
  logic [31:0] w_remainder_nxt;
  logic        r_dbz;
  logic        w_dbz_nxt;

  // The partial remainder stays below the divisor, so the shifted value fits
  // in 33 bits; bit 32 of the difference is the borrow of the trial subtract.
  logic [32:0] w_shift;
  logic [32:0] w_sub;
  logic [31:0] w_rem_step;
  logic [31:0] w_quo_step;

  assign w_shift    = {1'b0, r_rem} << 1 | {32'd0, r_dividend[31]};
  assign w_sub      = w_shift - {1'b0, r_divisor};
  assign w_rem_step = w_sub[32] ? w_shift[31:0] : w_sub[31:0];
  assign w_quo_step = {r_quo[30:0], ~w_sub[32]};

  // Next-state and next-register-value logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_dividend_nxt  = r_dividend;
    w_divisor_nxt   = r_divisor;
    w_rem_nxt       = r_rem;
    w_quo_nxt       = r_quo;
    w_count_nxt     = r_count;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_quotient_nxt  = r_quotient;
    w_remainder_nxt = r_remainder;
    w_dbz_nxt       = r_dbz;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_dividend_nxt = a;
          w_divisor_nxt  = b;
          w_rem_nxt      = 32'd0;
          w_quo_nxt      = 32'd0;
          w_count_nxt    = 5'd0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = (b == 32'd0) ? ZERO : DIVIDE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DIVIDE: begin
        w_dividend_nxt = {r_dividend[30:0], 1'b0};
        w_rem_nxt      = w_rem_step;
        w_quo_nxt      = w_quo_step;
        if (r_count == 5'd31) begin
          w_state_nxt     = IDLE;
          w_busy_nxt      = 1'b0;
          w_done_nxt      = 1'b1;
          w_quotient_nxt  = w_quo_step;
          w_remainder_nxt = w_rem_step;
          w_dbz_nxt       = 1'b0;
        end else begin
          w_count_nxt = r_count + 5'd1;
        end
      end
      ZERO: begin
        w_state_nxt     = IDLE;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b1;
        w_quotient_nxt  = 32'hFFFF_FFFF;
        w_remainder_nxt = r_dividend;
        w_dbz_nxt       = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dividend  <= 32'd0;
      r_divisor   <= 32'd0;
      r_rem       <= 32'd0;
      r_quo       <= 32'd0;
      r_count     <= 5'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= 32'd0;
      r_remainder <= 32'd0;
      r_dbz       <= 1'b0;
    end else begin
      r_dividend  <= w_dividend_nxt;
      r_divisor   <= w_divisor_nxt;
      r_rem       <= w_rem_nxt;
      r_quo       <= w_quo_nxt;
      r_count     <= w_count_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_quotient  <= w_quotient_nxt;
      r_remainder <= w_remainder_nxt;
      r_dbz       <= w_dbz_nxt;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div32by32.sv
// Directed self-checking bench for div32by32 with hand-computed results.
module tb_div32by32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks;
  int n_errors;

  div32by32 dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one division and follow it to completion, checking latency,
  // output stability while busy, and the final result.
  task automatic run_div(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz, input int ebusy,
                         input bit repulse, input bit tail, input string nm);
    int          nbusy;
    int          ndone;
    logic [31:0] q_hold;
    logic [31:0] r_hold;
    nbusy  = 0;
    ndone  = 0;
    q_hold = quotient;
    r_hold = remainder;
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    b     = 32'd0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL %s busy_after_start: got %b expected 1", nm, busy);
    end
    for (int c = 0; c < 100; c++) begin
      if (busy !== 1'b1) break;
      nbusy++;
      n_checks++;
      if (done !== 1'b0 || quotient !== q_hold || remainder !== r_hold) begin
        n_errors++;
        $display("FAIL %s hold_while_busy: got done=%b q=%0d r=%0d expected done=0 q=%0d r=%0d",
                 nm, done, quotient, remainder, q_hold, r_hold);
      end
      if (repulse && nbusy == 5) begin
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    n_checks++;
    if (nbusy != ebusy) begin
      n_errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", nm, nbusy, ebusy);
    end
    if (done === 1'b1) ndone++;
    n_checks++;
    if (done !== 1'b1) begin
      n_errors++;
      $display("FAIL %s done_pulse: got %b expected 1", nm, done);
    end
    n_checks++;
    if (quotient !== eq || remainder !== er || div_by_zero !== edbz) begin
      n_errors++;
      $display("FAIL %s result: got q=%0h r=%0h dbz=%b expected q=%0h r=%0h dbz=%b",
               nm, quotient, remainder, div_by_zero, eq, er, edbz);
    end
    if (tail) begin
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #1;
        if (done === 1'b1) ndone++;
      end
      n_checks++;
      if (ndone != 1 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL %s single_done: got %0d pulses busy=%b expected 1 pulse busy=0",
                 nm, ndone, busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 ||
        remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got busy=%b done=%b q=%0h r=%0h dbz=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    run_div(32'd211641329, 32'd3, 32'd70547109, 32'd2, 1'b0, 32, 1'b0, 1'b1, "basic");
  endtask

  task automatic test_extremes();
    run_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32, 1'b0, 1'b1, "max_by_1");
    run_div(32'd5, 32'd10, 32'd0, 32'd5, 1'b0, 32, 1'b0, 1'b1, "a_lt_b");
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32, 1'b0, 1'b1, "max_by_max");
    run_div(32'h8000_0000, 32'h0001_0001, 32'h0000_7FFF, 32'h0000_8001, 1'b0, 32, 1'b0, 1'b1, "msb_set");
  endtask

  task automatic test_div_by_zero();
    run_div(32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1, 1'b0, 1'b1, "div0");
    run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 1'b0, 1'b1, "after_div0");
  endtask

  task automatic test_ignore_start();
    run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 1'b1, 1'b1, "repulse");
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    @(negedge clk);
    start = 1'b1;
    a     = 32'd1000;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 ||
        remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_async: got busy=%b done=%b q=%0h r=%0h dbz=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    n_checks++;
    if (ndone != 0 || quotient !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_mid_abort: got %0d active cycles q=%0h expected 0 and q=0",
               ndone, quotient);
    end
    run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 1'b0, 1'b1, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_div(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 32, 1'b0, 1'b0, "b2b_first");
    run_div(32'd123456789, 32'd1000, 32'd123456, 32'd789, 1'b0, 32, 1'b0, 1'b0, "b2b_second");
    run_div(32'd77, 32'd0, 32'hFFFF_FFFF, 32'd77, 1'b1, 1, 1'b0, 1'b0, "b2b_zero");
    run_div(32'd50, 32'd8, 32'd6, 32'd2, 1'b0, 32, 1'b0, 1'b1, "b2b_after_zero");
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_div_by_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div32by32.md
DIV32BY32 -- requirements
Module: div32by32

Interface
REQ-001 No parameters; operand width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 start  input  1  request to begin a division; sampled on rising clk.
REQ-005 a  input  32  unsigned dividend; sampled only with accepted start.
REQ-006 b  input  32  unsigned divisor; sampled only with accepted start.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse when quotient/remainder are updated.
REQ-009 quotient  output  32  unsigned floor(a/b) of the last completed division.
REQ-010 remainder  output  32  unsigned a mod b of the last completed division.
REQ-011 div_by_zero  output  1  high when the last completed division had b = 0.

Function
REQ-012 The FSM SHALL have exactly three states:
- IDLE
- DIVIDE
- ZERO
REQ-013 In IDLE with start=1 at edge N, the block SHALL latch a and b and set busy=1 after edge N.
- Next state is DIVIDE with iteration count 0 if b != 0.
- Next state is ZERO if b = 0.
REQ-014 start SHALL be ignored in DIVIDE and ZERO; operands SHALL NOT be re-latched while busy=1.
REQ-015 DIVIDE SHALL perform one restoring shift-subtract iteration per cycle, MSB first, using a 33-bit partial remainder so no borrow is lost.
REQ-016 After the 32nd iteration, performed at edge N+32:
- quotient and remainder are updated.
- div_by_zero=0, done=1, busy=0.
- state returns to IDLE.
busy is therefore high for exactly 32 cycles.
REQ-017 ZERO SHALL last one cycle; at edge N+1:
- quotient=32'hFFFFFFFF, remainder=latched a, div_by_zero=1.
- done=1, busy=0, state=IDLE.
REQ-018 done SHALL be high for exactly one cycle per completed division and zero otherwise.
REQ-019 quotient, remainder and div_by_zero SHALL hold their values until the next completion; they SHALL NOT change during iterations.
REQ-020 An accepted start in the cycle after done (IDLE) SHALL begin a new division with no idle gap required.
REQ-021 Results SHALL be exact for all 2^64 operand pairs with b != 0: quotient*b + remainder = a and remainder < b.
REQ-022 a < b SHALL yield quotient=0 and remainder=a after the full 32-cycle latency.
REQ-023 No combinational path SHALL exist from any input to any output.

Reset
REQ-024 While reset=0, asynchronously and regardless of clk:
- state=IDLE.
- busy=0, done=0, div_by_zero=0.
- quotient=0, remainder=0.
- all internal registers cleared.
REQ-025 Reset asserted mid-division SHALL abort the operation; no done pulse and no partial result SHALL appear.
REQ-026 After reset release, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027 Basic division: a=211641329, b=3, start pulsed one cycle.
- busy=1 for exactly 32 cycles.
- Then quotient=70547109, remainder=2, done pulse, div_by_zero=0.
REQ-028 Extremes:
- a=32'hFFFFFFFF, b=1 -> quotient=32'hFFFFFFFF, remainder=0.
- Then a=5, b=10 -> quotient=0, remainder=5.
REQ-029 Divide by zero: a=1234, b=0.
- busy=1 for one cycle.
- Then quotient=32'hFFFFFFFF, remainder=1234, div_by_zero=1, done pulse.
- A following 100/7 clears div_by_zero and yields 14 r 2.
REQ-030 start re-pulsed with a=9, b=2 during a busy 100/7 -> ignored; result is 14 r 2, and exactly one done pulse occurs.
REQ-031 reset driven low at cycle 10 of a division, between clock edges:
- All outputs go to 0 immediately.
- No done pulse occurs.
- After release, 100/7 -> 14 r 2.
REQ-032 Back-to-back: start asserted in the cycle immediately after done -> accepted; second result is correct after 32 more cycles.
